cone_blitter: RTL
=================

Name: cone_blitter

Overview:
- Initiator/reader side of the palette sprite ROM interface for the cone sprite.
- On a start pulse it walks every sprite pixel in raster order and drives the ROM read address.
- It absorbs the ROM's 1-cycle read latency and discards chroma-key (transparent) pixels and off-screen pixels.
- Every remaining opaque pixel is written into the 640x480 framebuffer write port, with ready-based backpressure. It sits between the game-logic object placer and the framebuffer arbiter.

Parameters:
- SPR_W, 40, sprite width in pixels.
- SPR_H, 54, sprite height in pixels; SPR_W*SPR_H = 2160 ROM words.
- SCREEN_W, 640, framebuffer width.
- SCREEN_H, 480, framebuffer height.
- KEY_COLOR, 24'h00ff00, transparent colour; never written.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to draw; sampled only in IDLE.
- x0  in  10  sprite top-left X; latched on accepted start.
- y0  in  10  sprite top-left Y; latched on accepted start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the blit completes.
- rom_addr  out  12  registered ROM read address (row*SPR_W+col).
- rom_data  in  24  ROM colour; valid the cycle after rom_addr is presented.
- fb_we  out  1  framebuffer write request.
- fb_addr  out  19  linear framebuffer address (y*SCREEN_W+x).
- fb_data  out  24  pixel colour to write.
- fb_ready  in  1  framebuffer accepts the write in any cycle where fb_we && fb_ready.

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; busy=0, done=0, fb_we=0; rom_addr=0, fb_addr=0, fb_data=0; col/row counters=0.
- IDLE:
  - start=1 latches x0 and y0, clears col/row/rom_addr, and moves to FETCH.
  - start=0 stays in IDLE.
- FETCH: one wait cycle; the ROM samples rom_addr at the end of this cycle. Always moves to CHECK.
- CHECK: rom_data is valid. Compute sx = x0+col and sy = y0+row at 11 bits, no wrap.
  - If rom_data == KEY_COLOR, or sx >= SCREEN_W, or sy >= SCREEN_H: skip the pixel (advance).
  - Otherwise register fb_addr = sy*SCREEN_W+sx, fb_data = rom_data, set fb_we=1, and move to WRITE.
- WRITE:
  - fb_we, fb_addr and fb_data are held stable while fb_ready=0; no timeout.
  - On fb_we && fb_ready: clear fb_we and advance.
- Advance:
  - If col == SPR_W-1: col=0 and row++; otherwise col++.
  - rom_addr++.
  - If the pixel just finished was the last one (row == SPR_H-1 and col == SPR_W-1): go to DONE. Otherwise go to FETCH.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 during DONE.
- Throughput: skipped pixel = 2 cycles; opaque pixel = 3 cycles plus fb_ready stall cycles.
- start while busy: ignored, with no queueing. x0/y0 changes mid-blit have no effect.
- start in the same cycle as DONE: ignored. A new start is accepted in IDLE only.
- Reset mid-blit: immediate abort to reset values. No done pulse; an in-flight write is dropped.
- rom_addr never exceeds 2159; it is not wrapped and not incremented past the last pixel.

Decomposition:
- Shared package sprite_pkg:
  - SCREEN_W, SCREEN_H, FB_ADDR_W=19.
  - Colour typedef rgb24_t; KEY_COLOR.
  - The blitter state enum (IDLE, FETCH, CHECK, WRITE, DONE) for reuse by other sprite blitters.
- No sub-module required. Optionally factor the col/row/rom_addr raster walker as sprite_raster_ctr if sibling blitters (car, tree) share it.

Test Plan:
- All-transparent ROM model, start with x0=0, y0=0 -> fb_we never asserts; done pulses exactly 4320 cycles after busy rises.
- All-opaque ROM model (colour 24'hff512f), x0=100, y0=50, fb_ready=1:
  - 2160 writes.
  - First write fb_addr=32100, last write fb_addr=(103*640)+139=66059.
  - done 6480 cycles after busy.
- Clipping, x0=620, y0=470, opaque ROM -> only cols 0..19 and rows 0..9 written (200 writes); no fb_addr ≥ 307200.
- Backpressure, fb_ready low for 5 cycles on the first write -> fb_we, fb_addr and fb_data held constant for 5 cycles; the write completes on the 6th; rom_addr unchanged meanwhile.
- start pulsed during a blit with different x0 -> no effect on addresses; exactly one done pulse.
- Reset_n asserted mid-WRITE -> busy, fb_we, done and rom_addr are 0 immediately (asynchronously). After release a fresh start blits from rom_addr=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: screen geometry, colour type, chroma key and blitter state shared by sprite blitters
package sprite_pkg;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int FB_ADDR_W = 19;
    typedef logic [23:0] rgb24_t;
    localparam rgb24_t KEY_COLOR = 24'h00ff00;
    typedef enum logic [2:0] {IDLE, FETCH, CHECK, WRITE, DONE} blit_state_e;
endpackage

// File: rtl/sprite_raster_ctr.sv
// sprite_raster_ctr: raster-order col/row/ROM-address walker for a WxH sprite
module sprite_raster_ctr #(
    parameter int W = 40,
    parameter int H = 54,
    localparam int CW = $clog2(W),
    localparam int RW = $clog2(H),
    localparam int AW = $clog2(W * H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [AW-1:0] r_addr;
    logic          w_col_end;
    assign w_col_end = r_col == CW'(W - 1);
    assign o_last    = w_col_end && r_row == RW'(H - 1);
    assign o_col     = r_col;
    assign o_row     = r_row;
    assign o_addr    = r_addr;
    // the walker parks on the last pixel so the address never runs past the ROM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_clr) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_adv && !o_last) begin
            r_col  <= w_col_end ? '0 : r_col + 1'b1;
            r_row  <= w_col_end ? r_row + 1'b1 : r_row;
            r_addr <= r_addr + 1'b1;
        end
    end
endmodule

// File: rtl/cone_blitter.sv
// cone_blitter: reads the cone sprite ROM in raster order and writes opaque,
// on-screen pixels to the framebuffer with ready backpressure
module cone_blitter
    import sprite_pkg::*;
#(
    parameter int SPR_W = 40,
    parameter int SPR_H = 54
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic [9:0]           x0,
    input  logic [9:0]           y0,
    output logic                 busy,
    output logic                 done,
    output logic [11:0]          rom_addr,
    input  rgb24_t               rom_data,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output rgb24_t               fb_data,
    input  logic                 fb_ready
);
    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    blit_state_e          r_state, w_next;
    logic [9:0]           r_x0, r_y0;
    logic [FB_ADDR_W-1:0] r_fb_addr;
    rgb24_t               r_fb_data;
    logic [CW-1:0]        w_col;
    logic [RW-1:0]        w_row;
    logic [10:0]          w_sx, w_sy;
    logic                 w_start, w_opaque, w_adv, w_last;
    assign w_start  = r_state == IDLE && start;
    assign w_sx     = {1'b0, r_x0} + 11'(w_col);
    assign w_sy     = {1'b0, r_y0} + 11'(w_row);
    assign w_opaque = rom_data != KEY_COLOR && w_sx < 11'(SCREEN_W) && w_sy < 11'(SCREEN_H);
    assign w_adv    = (r_state == CHECK && !w_opaque) || (r_state == WRITE && fb_ready);
    assign busy     = r_state != IDLE;
    assign done     = r_state == DONE;
    assign fb_we    = r_state == WRITE;
    assign fb_addr  = r_fb_addr;
    assign fb_data  = r_fb_data;
    sprite_raster_ctr #(.W(SPR_W), .H(SPR_H)) u_raster (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .i_clr  (w_start),
        .i_adv  (w_adv),
        .o_col  (w_col),
        .o_row  (w_row),
        .o_addr (rom_addr),
        .o_last (w_last)
    );
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? FETCH : IDLE;
            FETCH:   w_next = CHECK;
            CHECK:   w_next = w_opaque ? WRITE : (w_last ? DONE : FETCH);
            WRITE:   w_next = !fb_ready ? WRITE : (w_last ? DONE : FETCH);
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // origin is captured once so mid-blit x0/y0 changes cannot shear the sprite
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x0      <= '0;
            r_y0      <= '0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else begin
            if (w_start) begin
                r_x0 <= x0;
                r_y0 <= y0;
            end
            if (r_state == CHECK && w_opaque) begin
                r_fb_addr <= FB_ADDR_W'(w_sy) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(w_sx);
                r_fb_data <= rom_data;
            end
        end
    end
endmodule
